// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg
// Shared definitions for the ID/EX operand stage that feeds the ALU.
// Contents:
//    DEF_XLEN / DEF_REG_AW : default datapath width and register-index width
//    ALU_*                 : 4-bit opcodes understood by the ALU
//    fwd_sel_e             : which source an operand is taken from
//    encodeOpcode          : funct3/funct7 -> ALU opcode translation
package alu_operand_stage_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int DEF_REG_AW = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   // funct3 shared by SRL/SRA; the only OP-IMM group where bit 30 matters
   localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   // R-type always uses bit 30 (ADD/SUB, SRL/SRA). For OP-IMM, bit 30 is part
   // of the immediate except for the right shifts, so ADDI never becomes SUB.
   function automatic logic [3:0] encodeOpcode(input logic       isRtype,
                                               input logic [2:0] funct3,
                                               input logic       funct7b5);
      if (isRtype || (funct3 == F3_SHIFT_RIGHT))
         return {funct7b5, funct3};
      else
         return {1'b0, funct3};
   endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
// Bundles every non-clock signal of the operand stage: the decode-side
// instruction and handshake, the EX/MEM and MEM/WB forwarding taps, the
// flush request and the registered ALU-side outputs with their handshake.
// Modports:
//    slave  : the operand stage itself
//    master : the surrounding pipeline (decode, hazard taps, ALU)
interface alu_operand_stage_if
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW
);

   logic              flush_in;
   logic              in_valid;
   logic              in_ready;
   logic              is_rtype_in;
   logic [2:0]        funct3_in;
   logic              funct7_b5_in;
   logic [REG_AW-1:0] rs1_addr_in;
   logic [REG_AW-1:0] rs2_addr_in;
   logic [REG_AW-1:0] rd_addr_in;
   logic [XLEN-1:0]   rs1_data_in;
   logic [XLEN-1:0]   rs2_data_in;
   logic [XLEN-1:0]   imm_in;
   logic              exmem_regwrite_in;
   logic [REG_AW-1:0] exmem_rd_in;
   logic [XLEN-1:0]   exmem_result_in;
   logic              memwb_regwrite_in;
   logic [REG_AW-1:0] memwb_rd_in;
   logic [XLEN-1:0]   memwb_result_in;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   op_1_out;
   logic [XLEN-1:0]   op_2_out;
   logic [3:0]        alu_opcode_out;
   logic [REG_AW-1:0] rd_addr_out;
   logic              regwrite_out;

   modport slave (
      input  flush_in, in_valid, is_rtype_in, funct3_in, funct7_b5_in,
             rs1_addr_in, rs2_addr_in, rd_addr_in, rs1_data_in, rs2_data_in,
             imm_in, exmem_regwrite_in, exmem_rd_in, exmem_result_in,
             memwb_regwrite_in, memwb_rd_in, memwb_result_in, out_ready,
      output in_ready, out_valid, op_1_out, op_2_out, alu_opcode_out,
             rd_addr_out, regwrite_out
   );

   modport master (
      output flush_in, in_valid, is_rtype_in, funct3_in, funct7_b5_in,
             rs1_addr_in, rs2_addr_in, rd_addr_in, rs1_data_in, rs2_data_in,
             imm_in, exmem_regwrite_in, exmem_rd_in, exmem_result_in,
             memwb_regwrite_in, memwb_rd_in, memwb_result_in, out_ready,
      input  in_ready, out_valid, op_1_out, op_2_out, alu_opcode_out,
             rd_addr_out, regwrite_out
   );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux
// Resolves one source operand: picks the EX/MEM result, the MEM/WB result or
// the register-file value, in that priority order. x0 is never forwarded.
// Ports:
//    srcAddr_i                  : source register index
//    rfData_i                   : register-file read value
//    exmemRegwrite_i/Rd_i/Result_i : EX/MEM writeback tap
//    memwbRegwrite_i/Rd_i/Result_i : MEM/WB writeback tap
//    operand_o                  : resolved operand value
module fwd_mux
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic [REG_AW-1:0] srcAddr_i,
   input  logic [XLEN-1:0]   rfData_i,
   input  logic              exmemRegwrite_i,
   input  logic [REG_AW-1:0] exmemRd_i,
   input  logic [XLEN-1:0]   exmemResult_i,
   input  logic              memwbRegwrite_i,
   input  logic [REG_AW-1:0] memwbRd_i,
   input  logic [XLEN-1:0]   memwbResult_i,
   output logic [XLEN-1:0]   operand_o
);

   fwd_sel_e fwdSel;

   // The younger EX/MEM result wins over MEM/WB when both target the same
   // register; a write to x0 is discarded by the register file, so it must
   // never be forwarded either.
   always_comb begin
      fwdSel = FWD_RF;
      if (exmemRegwrite_i && (exmemRd_i != '0) && (exmemRd_i == srcAddr_i))
         fwdSel = FWD_EXMEM;
      else if (memwbRegwrite_i && (memwbRd_i != '0) && (memwbRd_i == srcAddr_i))
         fwdSel = FWD_MEMWB;
   end

   // Plain operand mux driven by the selection above.
   always_comb begin
      operand_o = rfData_i;
      case (fwdSel)
         FWD_EXMEM: operand_o = exmemResult_i;
         FWD_MEMWB: operand_o = memwbResult_i;
         default:   operand_o = rfData_i;
      endcase
   end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// ID/EX stage in front of the ALU. Resolves both operands (forwarding or
// immediate), encodes the ALU opcode and holds the result in a one-entry
// valid/ready register whose outputs drive the ALU directly.
// Ports:
//    clk   : rising-edge clock
//    rst_n : asynchronous active-low reset, drops any held entry
//    bus   : alu_operand_stage_if.slave (decode inputs, forwarding taps,
//            flush, registered ALU outputs and both handshakes)
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_operand_stage_if.slave  bus
);

   logic              outValid_q, outValid_d;
   logic [XLEN-1:0]   op1_q, op1_d;
   logic [XLEN-1:0]   op2_q, op2_d;
   logic [3:0]        aluOpcode_q, aluOpcode_d;
   logic [REG_AW-1:0] rdAddr_q, rdAddr_d;
   logic              regwrite_q, regwrite_d;

   logic [XLEN-1:0]   fwdRs1;
   logic [XLEN-1:0]   fwdRs2;
   logic              inReady;
   logic              capture;

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) rs1Mux (
      .srcAddr_i       (bus.rs1_addr_in),
      .rfData_i        (bus.rs1_data_in),
      .exmemRegwrite_i (bus.exmem_regwrite_in),
      .exmemRd_i       (bus.exmem_rd_in),
      .exmemResult_i   (bus.exmem_result_in),
      .memwbRegwrite_i (bus.memwb_regwrite_in),
      .memwbRd_i       (bus.memwb_rd_in),
      .memwbResult_i   (bus.memwb_result_in),
      .operand_o       (fwdRs1)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) rs2Mux (
      .srcAddr_i       (bus.rs2_addr_in),
      .rfData_i        (bus.rs2_data_in),
      .exmemRegwrite_i (bus.exmem_regwrite_in),
      .exmemRd_i       (bus.exmem_rd_in),
      .exmemResult_i   (bus.exmem_result_in),
      .memwbRegwrite_i (bus.memwb_regwrite_in),
      .memwbRd_i       (bus.memwb_rd_in),
      .memwbResult_i   (bus.memwb_result_in),
      .operand_o       (fwdRs2)
   );

   // The slot frees up in the same cycle the ALU consumes it, which gives
   // back-to-back entries without a bubble. A flush blocks any capture.
   assign inReady = (!outValid_q || bus.out_ready) && !bus.flush_in;
   assign capture = bus.in_valid && inReady;

   // Next-state for the pipeline register. Flush beats capture and hold;
   // a drain only clears valid so the ALU inputs do not toggle needlessly.
   always_comb begin
      outValid_d  = outValid_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      aluOpcode_d = aluOpcode_q;
      rdAddr_d    = rdAddr_q;
      regwrite_d  = regwrite_q;
      if (bus.flush_in) begin
         outValid_d = 1'b0;
      end else if (capture) begin
         outValid_d  = 1'b1;
         op1_d       = fwdRs1;
         op2_d       = bus.is_rtype_in ? fwdRs2 : bus.imm_in;
         aluOpcode_d = encodeOpcode(bus.is_rtype_in, bus.funct3_in, bus.funct7_b5_in);
         rdAddr_d    = bus.rd_addr_in;
         regwrite_d  = (bus.rd_addr_in != '0);
      end else if (outValid_q && bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Pipeline register; reset clears everything so the ALU sees zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q  <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         aluOpcode_q <= '0;
         rdAddr_q    <= '0;
         regwrite_q  <= 1'b0;
      end else begin
         outValid_q  <= outValid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         aluOpcode_q <= aluOpcode_d;
         rdAddr_q    <= rdAddr_d;
         regwrite_q  <= regwrite_d;
      end
   end

   assign bus.in_ready       = inReady;
   assign bus.out_valid      = outValid_q;
   assign bus.op_1_out       = op1_q;
   assign bus.op_2_out       = op2_q;
   assign bus.alu_opcode_out = aluOpcode_q;
   assign bus.rd_addr_out    = rdAddr_q;
   assign bus.regwrite_out   = regwrite_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
// Directed bench for alu_operand_stage: reset values, opcode encoding,
// forwarding priority, backpressure, drain, flush and asynchronous reset
// while an entry is held.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic clk;
   logic rst_n;
   int   vectorCount;
   int   miscompareCount;

   alu_operand_stage_if bus ();

   alu_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one decoded instruction onto the input side.
   task automatic applyStimulus(input logic valid, input logic rtype,
                                input logic [2:0] f3, input logic f7b5,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] rs1Data,
                                input logic [31:0] rs2Data, input logic [31:0] imm);
      bus.in_valid     = valid;
      bus.is_rtype_in  = rtype;
      bus.funct3_in    = f3;
      bus.funct7_b5_in = f7b5;
      bus.rs1_addr_in  = rs1;
      bus.rs2_addr_in  = rs2;
      bus.rd_addr_in   = rd;
      bus.rs1_data_in  = rs1Data;
      bus.rs2_data_in  = rs2Data;
      bus.imm_in       = imm;
   endtask

   task automatic setForward(input logic exW, input logic [4:0] exRd,
                             input logic [31:0] exRes, input logic mwW,
                             input logic [4:0] mwRd, input logic [31:0] mwRes);
      bus.exmem_regwrite_in = exW;
      bus.exmem_rd_in       = exRd;
      bus.exmem_result_in   = exRes;
      bus.memwb_regwrite_in = mwW;
      bus.memwb_rd_in       = mwRd;
      bus.memwb_result_in   = mwRes;
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectorCount     = 0;
      miscompareCount = 0;
      rst_n           = 1'b0;
      bus.flush_in    = 1'b0;
      bus.out_ready   = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Reset values
      #12;
      checkOutput("reset_valid",    {31'b0, bus.out_valid},    32'h0);
      checkOutput("reset_op1",      bus.op_1_out,              32'h0);
      checkOutput("reset_op2",      bus.op_2_out,              32'h0);
      checkOutput("reset_opcode",   {28'b0, bus.alu_opcode_out}, 32'h0);
      checkOutput("reset_rd",       {27'b0, bus.rd_addr_out},  32'h0);
      checkOutput("reset_regwrite", {31'b0, bus.regwrite_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();

      // R-type SUB, no forwarding
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h3, 32'h0);
      #1;
      checkOutput("sub_in_ready", {31'b0, bus.in_ready}, 32'h1);
      stepCycle();
      checkOutput("sub_valid",    {31'b0, bus.out_valid},      32'h1);
      checkOutput("sub_op1",      bus.op_1_out,                32'h10);
      checkOutput("sub_op2",      bus.op_2_out,                32'h3);
      checkOutput("sub_opcode",   {28'b0, bus.alu_opcode_out}, 32'h8);
      checkOutput("sub_rd",       {27'b0, bus.rd_addr_out},    32'h3);
      checkOutput("sub_regwrite", {31'b0, bus.regwrite_out},   32'h1);

      // SRAI: bit 30 kept, immediate used as op_2, rd = x0
      applyStimulus(1'b1, 1'b0, 3'b101, 1'b1, 5'd4, 5'd9, 5'd0, 32'h8000_0000, 32'h77, 32'h404);
      stepCycle();
      checkOutput("srai_opcode",   {28'b0, bus.alu_opcode_out}, 32'hD);
      checkOutput("srai_op1",      bus.op_1_out,                32'h8000_0000);
      checkOutput("srai_op2",      bus.op_2_out,                32'h404);
      checkOutput("srai_regwrite", {31'b0, bus.regwrite_out},   32'h0);

      // ADDI with bit 30 set must stay ADD
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 5'd4, 5'd9, 5'd8, 32'h20, 32'h77, 32'h5);
      stepCycle();
      checkOutput("addi_opcode", {28'b0, bus.alu_opcode_out}, 32'h0);
      checkOutput("addi_op2",    bus.op_2_out,                32'h5);

      // SLTI / XORI / ANDI encodings
      applyStimulus(1'b1, 1'b0, 3'b010, 1'b1, 5'd4, 5'd9, 5'd8, 32'h20, 32'h77, 32'h5);
      stepCycle();
      checkOutput("slti_opcode", {28'b0, bus.alu_opcode_out}, 32'h2);
      applyStimulus(1'b1, 1'b1, 3'b111, 1'b0, 5'd4, 5'd9, 5'd8, 32'h20, 32'h77, 32'h5);
      stepCycle();
      checkOutput("and_opcode", {28'b0, bus.alu_opcode_out}, 32'h7);
      checkOutput("and_op2",    bus.op_2_out,                32'h77);

      // Forwarding priority on rs1: EX/MEM over MEM/WB
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 32'h1111, 32'h22, 32'h0);
      setForward(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
      stepCycle();
      checkOutput("fwd_exmem_op1", bus.op_1_out, 32'hAAAA);
      checkOutput("fwd_none_op2",  bus.op_2_out, 32'h22);

      // EX/MEM not writing: MEM/WB wins
      setForward(1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
      stepCycle();
      checkOutput("fwd_memwb_op1", bus.op_1_out, 32'hBBBB);

      // rs1 = x0 with both taps targeting x0: never forwarded
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 5'd6, 5'd7, 32'h1111, 32'h22, 32'h0);
      setForward(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
      stepCycle();
      checkOutput("fwd_x0_op1", bus.op_1_out, 32'h1111);

      // rs2 forwarded from MEM/WB while rs1 comes from EX/MEM
      applyStimulus(1'b1, 1'b1, 3'b110, 1'b0, 5'd3, 5'd7, 5'd9, 32'h1, 32'h2, 32'h0);
      setForward(1'b1, 5'd3, 32'hCCCC, 1'b1, 5'd7, 32'hDDDD);
      stepCycle();
      checkOutput("fwd_rs1_ex_op1", bus.op_1_out,                32'hCCCC);
      checkOutput("fwd_rs2_mw_op2", bus.op_2_out,                32'hDDDD);
      checkOutput("or_opcode",      {28'b0, bus.alu_opcode_out}, 32'h6);
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Backpressure: held entry (op1 0xCCCC) must not change for 3 cycles
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd10, 32'h5555, 32'h6, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'h0);
         stepCycle();
         checkOutput("bp_valid", {31'b0, bus.out_valid}, 32'h1);
         checkOutput("bp_op1",   bus.op_1_out,           32'hCCCC);
         checkOutput("bp_rd",    {27'b0, bus.rd_addr_out}, 32'h9);
      end
      bus.out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", {31'b0, bus.in_ready}, 32'h1);
      stepCycle();
      checkOutput("bp_cap_valid", {31'b0, bus.out_valid}, 32'h1);
      checkOutput("bp_cap_op1",   bus.op_1_out,           32'h5555);
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd11, 32'h6666, 32'h6, 32'h0);
      stepCycle();
      checkOutput("b2b_valid", {31'b0, bus.out_valid}, 32'h1);
      checkOutput("b2b_op1",   bus.op_1_out,           32'h6666);

      // Drain: valid drops, data registers keep their values
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd12, 32'h9999, 32'h6, 32'h0);
      stepCycle();
      checkOutput("drain_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("drain_op1",   bus.op_1_out,           32'h6666);

      // Flush with held entry and a concurrent incoming instruction
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd13, 32'h7777, 32'h6, 32'h0);
      stepCycle();
      checkOutput("pre_flush_valid", {31'b0, bus.out_valid}, 32'h1);
      bus.out_ready = 1'b0;
      bus.flush_in  = 1'b1;
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd14, 32'h8888, 32'h6, 32'h0);
      #1;
      checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'h0);
      stepCycle();
      checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'h0);
      checkOutput("flush_op1",   bus.op_1_out,           32'h7777);
      bus.flush_in  = 1'b0;
      bus.out_ready = 1'b1;

      // Asynchronous reset while an entry is held
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 5'd1, 5'd2, 5'd15, 32'h9999, 32'h44, 32'h0);
      stepCycle();
      bus.out_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("hold_valid",  {31'b0, bus.out_valid},      32'h1);
      checkOutput("hold_opcode", {28'b0, bus.alu_opcode_out}, 32'h8);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid",    {31'b0, bus.out_valid},      32'h0);
      checkOutput("arst_op1",      bus.op_1_out,                32'h0);
      checkOutput("arst_op2",      bus.op_2_out,                32'h0);
      checkOutput("arst_opcode",   {28'b0, bus.alu_opcode_out}, 32'h0);
      checkOutput("arst_regwrite", {31'b0, bus.regwrite_out},   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();
      checkOutput("post_rst_valid", {31'b0, bus.out_valid}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. It accepts a decoded integer instruction and resolves both operands: register-file value, EX/MEM forward, MEM/WB forward, or immediate. It encodes funct3/funct7 into the ALU's 4-bit opcode and registers everything for a one-entry valid/ready handoff. Its registered outputs drive the ALU operand and opcode inputs directly.

Parameters:
XLEN, 32, datapath width; equals the ALU operand width.
REG_AW, 5, register address width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush_in  in  1  kill the held entry and block capture this cycle (branch/trap)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
is_rtype_in  in  1  1 = R-type, 0 = OP-IMM
funct3_in  in  3  instruction funct3
funct7_b5_in  in  1  instruction bit 30
rs1_addr_in  in  REG_AW  source 1 index
rs2_addr_in  in  REG_AW  source 2 index
rd_addr_in  in  REG_AW  destination index
rs1_data_in  in  XLEN  register-file read 1
rs2_data_in  in  XLEN  register-file read 2
imm_in  in  XLEN  sign-extended immediate
exmem_regwrite_in  in  1  EX/MEM result will be written
exmem_rd_in  in  REG_AW  EX/MEM destination
exmem_result_in  in  XLEN  EX/MEM result
memwb_regwrite_in  in  1  MEM/WB result will be written
memwb_rd_in  in  REG_AW  MEM/WB destination
memwb_result_in  in  XLEN  MEM/WB result
out_valid  out  1  registered entry valid
out_ready  in  1  downstream consumes the entry
op_1_out  out  XLEN  ALU operand 1
op_2_out  out  XLEN  ALU operand 2
alu_opcode_out  out  4  ALU opcode
rd_addr_out  out  REG_AW  destination passed along
regwrite_out  out  1  1 when rd_addr_out != 0

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, op_1_out, op_2_out, alu_opcode_out, rd_addr_out and regwrite_out to 0. Reset can interrupt any state, and the held entry is lost.
- in_ready = !out_valid || out_ready (combinational). flush_in forces in_ready to 0.
- Capture: when in_valid && in_ready && !flush_in at a clock edge, all output registers load and out_valid is set to 1. Latency is 1 cycle from acceptance to out_valid.
- Hold: when out_valid && !out_ready, all outputs stay stable and no capture happens.
- Drain: when out_valid && out_ready with no new capture, out_valid goes to 0. Data registers keep their old values.
- Flush: flush_in at a clock edge clears out_valid, and any concurrent in_valid is dropped. Flush takes priority over capture and hold.
- Forwarding is applied per source at capture time, with priority EX/MEM > MEM/WB > register file:
  - EX/MEM hit: exmem_regwrite_in && exmem_rd_in != 0 && exmem_rd_in == rsN_addr_in.
  - MEM/WB hit: same test against the memwb inputs.
  - x0 is never forwarded.
- Operand selection:
  - op_1 = forwarded rs1.
  - op_2 = imm_in when is_rtype_in = 0, otherwise forwarded rs2. No forwarding applies to the immediate.
- Opcode encoding:
  - R-type: {funct7_b5_in, funct3_in}.
  - OP-IMM with funct3 = 101: {funct7_b5_in, 101} (SRLI/SRAI).
  - OP-IMM otherwise: {0, funct3_in}, so bit 30 is ignored (ADDI is never SUB).
- Resulting ALU codes: add 0000, sub 1000, slt 0010, sltu 0011, xor 0100, or 0110, and 0111, sll 0001, srl 0101, sra 1101.
- The stage does not range-check the shift amount; the ALU consumes op_2 as given.
- regwrite_out is registered as (rd_addr_in != 0) on capture.
- The stage does not detect or stall for load-use hazards; decode must handle them before asserting in_valid.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (ALU_ADD=4'b0000 … ALU_SRA=4'b1101).
  - XLEN/REG_AW defaults.
  - Forward-select encoding (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10).
- One sub-module, fwd_mux: combinational hit detection plus operand mux, instantiated twice (rs1, rs2). The opcode encoder and pipeline register stay inline.

Test Plan:
- Reset mid-hold:
  - Stimulus: capture an entry, hold with out_ready=0, then pulse rst_n low.
  - Response: out_valid, op_1_out, op_2_out and alu_opcode_out are 0 immediately, without waiting for a clock edge.
- R-type SUB:
  - Stimulus: funct3=000, funct7_b5=1, rs1_data=0x10, rs2_data=0x3, no forwarding.
  - Response: one cycle later out_valid=1, op_1=0x10, op_2=0x3, opcode=1000.
- I-type shifts and ADDI:
  - Stimulus: SRAI with funct3=101, funct7_b5=1, imm=0x404 → opcode=1101, op_2=0x404.
  - Stimulus: ADDI with funct3=000, funct7_b5=1 → opcode=0000.
- Forward priority:
  - Stimulus: rs1=5, exmem_rd=5 with result 0xAAAA, memwb_rd=5 with result 0xBBBB, both regwrite=1 → op_1=0xAAAA.
  - Stimulus: repeat with exmem_regwrite=0 → op_1=0xBBBB.
  - Stimulus: repeat with rs1=0 → op_1 = rs1_data_in.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1 with new data.
  - Response: in_ready=0 and outputs unchanged across those cycles.
  - Stimulus: raise out_ready.
  - Response: the same-cycle capture succeeds, giving back-to-back entries with no bubble.
- Flush:
  - Stimulus: flush_in=1 coinciding with in_valid=1 and out_valid=1.
  - Response: next cycle out_valid=0, and the incoming instruction is not captured.
